// File: rtl/persp_div_seq_pkg.sv
// persp_pkg: shared widths, FSM encoding and saturation constant for the perspective divider
package persp_pkg;
  function automatic int W(input int ib, input int fb);
    return ib + fb + 1;
  endfunction
  function automatic int ITER(input int ib, input int fb);
    return ib + 2 * fb;
  endfunction
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/persp_div_lane.sv
// persp_div_lane: one restoring-division lane with sign restore and saturation
module persp_div_lane
  import persp_pkg::*;
#(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8,
  localparam int WD = W(INT_BITS, FRAC_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          fin_i,
  input  logic [WD-1:0] num_i,
  input  logic          z_sign_i,
  input  logic [WD-1:0] zmag_i,
  output logic [WD-1:0] q_o,
  output logic          ovf_o
);
  localparam int IT = ITER(INT_BITS, FRAC_BITS);
  localparam logic [WD-1:0] SATM = WD'(sat_max(WD));
  logic [WD-1:0] rem_q, rem_d, q_q, q_d, mag, qmag;
  logic [IT-1:0] dq_q, dq_d;
  logic [WD:0] rem_sh, rem_sub;
  logic neg_q, neg_d, nz_q, nz_d, big_q, big_d, ovf_q, ovf_d, ge, sat;
  // |num| needs all WD bits so the most negative operand stays exact; its top bit seeds the remainder
  assign mag = num_i[WD-1] ? -num_i : num_i;
  assign rem_sh = {rem_q, dq_q[IT-1]};
  assign ge = rem_sh >= {1'b0, zmag_i};
  assign rem_sub = rem_sh - {1'b0, zmag_i};
  // quotient bits above the result range, or the seeded top bit over a unit divisor, mean saturation
  assign sat = nz_q && ((|dq_q[IT-1:WD-1]) || (big_q && zmag_i == WD'(1)));
  assign qmag = sat ? SATM : {1'b0, dq_q[WD-2:0]};
  assign q_o = q_q;
  assign ovf_o = ovf_q;
  // load operands, shift one quotient bit per step, format the result on finish
  always_comb begin
    rem_d = load_i ? {{(WD-1){1'b0}}, mag[WD-1]} : step_i ? WD'(ge ? rem_sub : rem_sh) : rem_q;
    dq_d = load_i ? {mag[WD-2:0], {FRAC_BITS{1'b0}}} : step_i ? {dq_q[IT-2:0], ge} : dq_q;
    neg_d = load_i ? num_i[WD-1] ^ z_sign_i : neg_q;
    nz_d = load_i ? |num_i : nz_q;
    big_d = load_i ? mag[WD-1] : big_q;
    q_d = fin_i ? (!nz_q ? '0 : neg_q ? -qmag : qmag) : q_q;
    ovf_d = fin_i ? sat : ovf_q;
  end
  // lane state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      dq_q  <= '0;
      neg_q <= 1'b0;
      nz_q  <= 1'b0;
      big_q <= 1'b0;
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      dq_q  <= dq_d;
      neg_q <= neg_d;
      nz_q  <= nz_d;
      big_q <= big_d;
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/persp_div_seq.sv
// persp_div_seq: sequential multi-channel signed fixed-point divide by a shared z
module persp_div_seq
  import persp_pkg::*;
#(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 8,
  parameter int CHANNELS  = 2,
  localparam int WD = W(INT_BITS, FRAC_BITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHANNELS*WD-1:0] in_num,
  input  logic [WD-1:0]          in_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHANNELS*WD-1:0] out_q,
  output logic [CHANNELS-1:0]    out_ovf,
  output logic                   out_div_zero
);
  localparam int IT = ITER(INT_BITS, FRAC_BITS);
  localparam int CW = $clog2(IT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WD-1:0] zmag_q, zmag_d;
  logic dz_q, dz_d, load, step, fin;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_div_zero = dz_q;
  assign load = in_valid && in_ready;
  // RUN spends IT cycles producing quotient bits and one more formatting the registered result
  assign step = state_q == RUN && cnt_q != '0;
  assign fin = state_q == RUN && cnt_q == '0;
  // next state, iteration count, divisor magnitude and zero flag
  always_comb begin
    state_d = load ? RUN : fin ? DONE : (out_valid && out_ready) ? IDLE : state_q;
    cnt_d = load ? CW'(IT) : step ? cnt_q - CW'(1) : cnt_q;
    zmag_d = load ? (in_z[WD-1] ? -in_z : in_z) : zmag_q;
    dz_d = fin ? zmag_q == '0 : dz_q;
  end
  // control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      zmag_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zmag_q  <= zmag_d;
      dz_q    <= dz_d;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    persp_div_lane #(.INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .step_i   (step),
      .fin_i    (fin),
      .num_i    (in_num[c*WD +: WD]),
      .z_sign_i (in_z[WD-1]),
      .zmag_i   (zmag_q),
      .q_o      (out_q[c*WD +: WD]),
      .ovf_o    (out_ovf[c])
    );
  end
endmodule

// File: tb/tb_persp_div_seq.sv
// tb_persp_div_seq: scoreboard bench for the sequential perspective divider
module tb_persp_div_seq;
  localparam int MAXQ = 65535;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [33:0] in_num = '0;
  logic [16:0] in_z = '0;
  logic in_ready, out_valid, out_div_zero;
  logic [33:0] out_q;
  logic [1:0] out_ovf;
  typedef struct {
    logic [33:0] q;
    logic [1:0]  ovf;
    logic        dz;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  persp_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_ovf(out_ovf), .out_div_zero(out_div_zero)
  );

  function automatic void lane_model(input int n, input int z, output logic [16:0] q, output logic ov);
    longint a, m;
    int r;
    if (z == 0) begin
      r = n > 0 ? MAXQ : n < 0 ? -MAXQ : 0;
      ov = n != 0;
    end else begin
      a = longint'(n < 0 ? -n : n) * 256;
      m = a / longint'(z < 0 ? -z : z);
      ov = m > MAXQ;
      if (ov) m = MAXQ;
      r = ((n < 0) != (z < 0)) ? -int'(m) : int'(m);
    end
    q = r[16:0];
  endfunction

  task automatic send(input int n0, input int n1, input int z);
    exp_t e;
    logic [16:0] q0, q1;
    logic o0, o1;
    int k = 0;
    lane_model(n0, z, q0, o0);
    lane_model(n1, z, q1, o1);
    e.q = {q1, q0};
    e.ovf = {o1, o0};
    e.dz = z == 0;
    sb.push_back(e);
    in_num = {n1[16:0], n0[16:0]};
    in_z = z[16:0];
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input int stall, output int lat);
    exp_t e;
    logic [33:0] held;
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL result_timeout out_valid=%b required 1 (pending=%0d)", out_valid, sb.size());
      sb.delete();
      return;
    end
    held = out_q;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_num = {$urandom, $urandom};
      in_z = 17'd1;
      @(posedge clk); #1;
      checks++;
      if (out_q !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold q=%h valid=%b ready=%b required q=%h valid=1 ready=0", out_q, out_valid, in_ready, held);
      end
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_q !== e.q) begin
      errors++;
      $display("FAIL out_q got %h required %h", out_q, e.q);
    end
    checks++;
    if (out_ovf !== e.ovf) begin
      errors++;
      $display("FAIL out_ovf got %b required %b", out_ovf, e.ovf);
    end
    checks++;
    if (out_div_zero !== e.dz) begin
      errors++;
      $display("FAIL out_div_zero got %b required %b", out_div_zero, e.dz);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_q, out_ovf, out_div_zero} !== {1'b1, 1'b0, 34'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state ready=%b valid=%b q=%h ovf=%b dz=%b required 1 0 0 00 0",
               in_ready, out_valid, out_q, out_ovf, out_div_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int lat;
    send(256, -768, 512);
    recv(0, lat);
    checks++;
    if (lat != 25) begin
      errors++;
      $display("FAIL latency got %0d required 25", lat);
    end
  endtask

  task automatic test_arith;
    int lat;
    int cases[6][3] = '{'{-768, 25600, -384}, '{25600, -25600, 64}, '{300, 0, 0},
                        '{-65536, 0, 256}, '{-300, 65535, 1}, '{1, -1, -65536}};
    foreach (cases[i]) begin
      send(cases[i][0], cases[i][1], cases[i][2]);
      recv(0, lat);
    end
    for (int i = 0; i < 10; i++) begin
      send(int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
           (i % 3 == 0) ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 131071)) - 65536);
      recv(0, lat);
    end
  endtask

  task automatic test_stall;
    int lat;
    send(25600, -25600, 64);
    recv(6, lat);
  endtask

  task automatic test_reset_mid;
    int lat;
    send(1000, -2000, -300);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_q, out_ovf, out_div_zero} !== {1'b1, 1'b0, 34'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset ready=%b valid=%b q=%h ovf=%b dz=%b required 1 0 0 00 0",
               in_ready, out_valid, out_q, out_ovf, out_div_zero);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(-65536, 512, 256);
    recv(0, lat);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
